// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART transmit arbiter.
package uart_pkg;

    localparam int CLK_FREQ_HZ      = 50_000_000;
    localparam int BAUD_RATE        = 115_200;
    localparam int DEFAULT_BAUD_DIV = CLK_FREQ_HZ / BAUD_RATE;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_WAIT_HI = 2'd2,
        S_WAIT_LO = 2'd3
    } state_t;

    function automatic int wrap_inc(input int i, input int n);
        return (i + 1) % n;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running baud divider: one-cycle tick every BAUD_DIV clocks.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic clk_50m,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = $clog2(BAUD_DIV);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(BAUD_DIV - 1));

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n)    cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of a shared byte UART transmitter; the grant is held
// for a whole packet and each byte is handed over as a load + busy handshake.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int BAUD_DIV    = DEFAULT_BAUD_DIV,
    parameter int WAIT_HI_MAX = 3
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           tx_din,
    output logic                 tx_wr_en,
    output logic                 tx_clken,
    input  logic                 tx_busy,
    output logic                 err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WC_W  = $clog2(WAIT_HI_MAX + 1);

    state_t             state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   rr_ptr;
    logic               last_q;
    logic [WC_W-1:0]    wait_cnt;

    uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .tick    (tx_clken)
    );

    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                  input logic [IDX_W-1:0]   ptr);
        logic found;
        int   idx;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && r[idx]) begin
                found   = 1'b1;
                rr_pick = IDX_W'(idx);
            end
        end
    endfunction

    // Strobes decode only from registered state/grant so they cannot glitch.
    assign tx_wr_en = (state == S_LOAD);
    assign req_ack  = tx_wr_en ? grant : '0;
    assign tx_din   = tx_wr_en ? req_data[{owner, 3'b000} +: 8] : 8'h00;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            grant    <= '0;
            last_q   <= 1'b0;
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // A busy transmitter here is a frame left over from before reset.
                    if (|req && !tx_busy) begin
                        owner <= rr_pick(req, rr_ptr);
                        grant <= NUM_REQ'(1) << rr_pick(req, rr_ptr);
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    last_q   <= req_last[owner];
                    wait_cnt <= '0;
                    state    <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (tx_busy) begin
                        state <= S_WAIT_LO;
                    end else if (wait_cnt == WC_W'(WAIT_HI_MAX - 1)) begin
                        err    <= 1'b1;
                        grant  <= '0;
                        rr_ptr <= IDX_W'(wrap_inc(int'(owner), NUM_REQ));
                        state  <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (last_q || !req[owner]) begin
                            grant  <= '0;
                            rr_ptr <= IDX_W'(wrap_inc(int'(owner), NUM_REQ));
                            state  <= S_IDLE;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench: requester queues and a transmitter model around the
// arbiter, frames checked against a packet-level round-robin reference.
module tb_uart_tx_arbiter;

    localparam int NR  = 4;
    localparam int BD  = 4;
    localparam int WHM = 3;
    localparam int TMO = 4000;

    logic            clk_50m = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ack;
    logic [NR-1:0]   grant;
    logic [7:0]      tx_din;
    logic            tx_wr_en;
    logic            tx_clken;
    logic            tx_busy;
    logic            err;

    always #10 clk_50m = ~clk_50m;

    uart_tx_arbiter #(.NUM_REQ(NR), .BAUD_DIV(BD), .WAIT_HI_MAX(WHM)) dut (
        .clk_50m  (clk_50m),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .req_ack  (req_ack),
        .grant    (grant),
        .tx_din   (tx_din),
        .tx_wr_en (tx_wr_en),
        .tx_clken (tx_clken),
        .tx_busy  (tx_busy),
        .err      (err)
    );

    typedef struct packed {
        logic [NR-1:0] ack;
        logic [NR-1:0] gnt;
        logic [7:0]    din;
    } obs_t;

    logic [8:0]  rq[NR][$];      // {last, byte} per requester
    obs_t        obs_q[$];
    logic [9:0]  exp_q[$];       // {requester, byte}
    logic [NR-1:0] ack_pend = '0;
    int          model_ptr = 0;
    int          bad_wr = 0;
    int          vecs = 0;
    int          miscompares = 0;

    // Transmitter model: busy the cycle after a load, for 10 baud ticks; not reset.
    logic stub = 1'b0;
    logic busy_m = 1'b0;
    int   tick_cnt = 0;
    assign tx_busy = stub ? 1'b0 : busy_m;

    always @(posedge clk_50m) begin
        if (!busy_m) begin
            if (tx_wr_en && !stub) begin
                busy_m   <= 1'b1;
                tick_cnt <= 0;
            end
        end else if (tx_clken) begin
            if (tick_cnt == 9) busy_m <= 1'b0;
            else               tick_cnt <= tick_cnt + 1;
        end
    end

    // Requesters pop a byte the cycle after its ack, then present the next one.
    always @(negedge clk_50m) begin
        obs_t o;
        for (int i = 0; i < NR; i++) begin
            if (ack_pend[i] && rq[i].size() != 0) void'(rq[i].pop_front());
            ack_pend[i] = req_ack[i];
        end
        for (int i = 0; i < NR; i++) begin
            req[i] = (rq[i].size() != 0);
            req_data[8*i +: 8] = req[i] ? rq[i][0][7:0] : 8'h00;
            req_last[i] = req[i] ? rq[i][0][8] : 1'b0;
        end
        if (tx_wr_en) begin
            o.ack = req_ack;
            o.gnt = grant;
            o.din = tx_din;
            obs_q.push_back(o);
            if (tx_busy) bad_wr++;
        end
    end

    task automatic push_byte(input int r, input logic [7:0] b, input logic last);
        rq[r].push_back({last, b});
    endtask

    task automatic push_rand_pkt(input int r);
        int len;
        len = $urandom_range(1, 3);
        for (int k = 0; k < len; k++) push_byte(r, 8'($urandom), k == len - 1);
    endtask

    // Reference: whole packets, one per turn, first non-empty queue from the pointer.
    task automatic build_expected();
        logic [8:0] cp[NR][$];
        logic [8:0] e;
        int idx;
        for (int i = 0; i < NR; i++) cp[i] = rq[i];
        forever begin
            idx = -1;
            for (int k = 0; k < NR; k++)
                if (idx < 0 && cp[(model_ptr + k) % NR].size() != 0) idx = (model_ptr + k) % NR;
            if (idx < 0) break;
            while (cp[idx].size() != 0) begin
                e = cp[idx].pop_front();
                exp_q.push_back({idx[1:0], e[7:0]});
                if (e[8]) break;
            end
            model_ptr = (idx + 1) % NR;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        logic pending;
        repeat (2) @(negedge clk_50m);
        forever begin
            pending = 1'b0;
            for (int i = 0; i < NR; i++) if (rq[i].size() != 0) pending = 1'b1;
            if (!pending && !tx_busy && grant == '0 && !tx_wr_en) break;
            if (n >= TMO) break;
            @(negedge clk_50m);
            n++;
        end
        vecs++;
        if (n >= TMO) begin
            miscompares++;
            $display("FAIL %s_timeout: still busy after %0d cycles, limit %0d", name, n, TMO);
        end
        repeat (2) @(negedge clk_50m);
    endtask

    task automatic do_reset();
        @(negedge clk_50m);
        rst_n = 1'b0;
        model_ptr = 0;
        repeat (2) @(negedge clk_50m);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        vecs++;
        if (grant !== '0 || req_ack !== '0 || tx_wr_en !== 1'b0 || tx_clken !== 1'b0 ||
            err !== 1'b0 || tx_din !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_outputs: got gnt=%b ack=%b wr=%b clken=%b err=%b din=%h, want all 0",
                     grant, req_ack, tx_wr_en, tx_clken, err, tx_din);
        end
        repeat (3) @(negedge clk_50m);
        rst_n = 1'b1;
    endtask

    task automatic test_baud();
        int last = -1, ticks = 0, bad_int = 0, bad_idle = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_50m);
            if (tx_clken) begin
                if (last >= 0 && c - last != BD) bad_int++;
                last = c;
                ticks++;
            end
            if (grant !== '0 || tx_wr_en !== 1'b0) bad_idle++;
        end
        vecs++;
        if (ticks != 40 / BD) begin
            miscompares++;
            $display("FAIL baud_count: got %0d ticks in 40 cycles, want %0d", ticks, 40 / BD);
        end
        vecs++;
        if (bad_int != 0) begin
            miscompares++;
            $display("FAIL baud_period: %0d tick gaps differ from %0d, want 0", bad_int, BD);
        end
        vecs++;
        if (bad_idle != 0) begin
            miscompares++;
            $display("FAIL baud_idle: %0d cycles with grant/wr_en set, want 0", bad_idle);
        end
    endtask

    task automatic test_single();
        obs_q.delete(); exp_q.delete();
        @(negedge clk_50m);
        push_byte(0, 8'hA5, 1'b1);
        build_expected();
        drain("single");
        vecs++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL single_frames: got %0d frames, want %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            logic [NR-1:0] oh;
            oh = NR'(1) << exp_q[k][9:8];
            vecs++;
            if (obs_q[k].ack !== oh || obs_q[k].gnt !== oh || obs_q[k].din !== exp_q[k][7:0]) begin
                miscompares++;
                $display("FAIL single_frame%0d: got ack=%b gnt=%b din=%h, want ack=gnt=%b din=%h",
                         k, obs_q[k].ack, obs_q[k].gnt, obs_q[k].din, oh, exp_q[k][7:0]);
            end
        end
        vecs++;
        if (grant !== '0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL single_release: got gnt=%b err=%b, want 0 0", grant, err);
        end
    endtask

    task automatic test_alternate();
        obs_q.delete(); exp_q.delete();
        @(negedge clk_50m);
        for (int k = 0; k < 3; k++) begin
            push_byte(1, 8'($urandom), 1'b1);
            push_byte(3, 8'($urandom), 1'b1);
        end
        build_expected();
        drain("alternate");
        vecs++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL alternate_frames: got %0d frames, want %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            logic [NR-1:0] oh;
            oh = NR'(1) << exp_q[k][9:8];
            vecs++;
            if (obs_q[k].ack !== oh || obs_q[k].gnt !== oh || obs_q[k].din !== exp_q[k][7:0]) begin
                miscompares++;
                $display("FAIL alternate_frame%0d: got ack=%b gnt=%b din=%h, want ack=gnt=%b din=%h",
                         k, obs_q[k].ack, obs_q[k].gnt, obs_q[k].din, oh, exp_q[k][7:0]);
            end
        end
    endtask

    task automatic test_multi_byte();
        // A one-byte packet from requester 1 first moves the pointer to 2.
        @(negedge clk_50m);
        push_byte(1, 8'h5C, 1'b1);
        build_expected();
        drain("multi_pre");
        obs_q.delete(); exp_q.delete();
        @(negedge clk_50m);
        push_byte(2, 8'h11, 1'b0);
        push_byte(2, 8'h22, 1'b0);
        push_byte(2, 8'h33, 1'b1);
        push_byte(0, 8'h77, 1'b1);
        build_expected();
        drain("multi");
        vecs++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL multi_frames: got %0d frames, want %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            logic [NR-1:0] oh;
            oh = NR'(1) << exp_q[k][9:8];
            vecs++;
            if (obs_q[k].ack !== oh || obs_q[k].gnt !== oh || obs_q[k].din !== exp_q[k][7:0]) begin
                miscompares++;
                $display("FAIL multi_frame%0d: got ack=%b gnt=%b din=%h, want ack=gnt=%b din=%h",
                         k, obs_q[k].ack, obs_q[k].gnt, obs_q[k].din, oh, exp_q[k][7:0]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            obs_q.delete(); exp_q.delete();
            @(negedge clk_50m);
            for (int r = 0; r < NR; r++) begin
                int npk;
                npk = $urandom_range(0, 2);
                for (int p = 0; p < npk; p++) push_rand_pkt(r);
            end
            build_expected();
            drain("random");
            vecs++;
            if (obs_q.size() != exp_q.size()) begin
                miscompares++;
                $display("FAIL random%0d_frames: got %0d frames, want %0d", it, obs_q.size(), exp_q.size());
            end
            for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
                logic [NR-1:0] oh;
                oh = NR'(1) << exp_q[k][9:8];
                vecs++;
                if (obs_q[k].ack !== oh || obs_q[k].gnt !== oh || obs_q[k].din !== exp_q[k][7:0]) begin
                    miscompares++;
                    $display("FAIL random%0d_frame%0d: got ack=%b gnt=%b din=%h, want ack=gnt=%b din=%h",
                             it, k, obs_q[k].ack, obs_q[k].gnt, obs_q[k].din, oh, exp_q[k][7:0]);
                end
            end
        end
    endtask

    task automatic test_err();
        int n = 0;
        int bad = 0;
        stub = 1'b1;
        @(negedge clk_50m);
        push_byte(1, 8'h3C, 1'b1);
        while (!tx_wr_en && n < 50) begin
            @(negedge clk_50m);
            n++;
        end
        vecs++;
        if (!tx_wr_en) begin
            miscompares++;
            $display("FAIL err_load: no tx_wr_en within %0d cycles, want one", n);
        end
        repeat (WHM) @(negedge clk_50m);
        vecs++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_early: got err=%b after %0d wait cycles, want 0", err, WHM - 1);
        end
        @(negedge clk_50m);
        vecs++;
        if (err !== 1'b1 || grant !== '0) begin
            miscompares++;
            $display("FAIL err_set: got err=%b gnt=%b, want err=1 gnt=0", err, grant);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_50m);
            if (err !== 1'b1 || tx_wr_en !== 1'b0) bad++;
        end
        vecs++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL err_sticky: %0d cycles with err=0 or wr_en=1, want 0", bad);
        end
        stub = 1'b0;
        do_reset();
        #1;
        vecs++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear: got err=%b after reset, want 0", err);
        end
        obs_q.delete();
    endtask

    task automatic test_reset_midframe();
        int n = 0;
        obs_q.delete(); exp_q.delete();
        bad_wr = 0;
        @(negedge clk_50m);
        push_byte(0, 8'($urandom), 1'b0);
        push_byte(0, 8'($urandom), 1'b0);
        push_byte(0, 8'($urandom), 1'b1);
        build_expected();
        while (!tx_busy && n < 50) begin
            @(negedge clk_50m);
            n++;
        end
        repeat (3) @(negedge clk_50m);
        vecs++;
        if (tx_busy !== 1'b1 || grant !== 4'b0001) begin
            miscompares++;
            $display("FAIL midframe_setup: got busy=%b gnt=%b, want busy=1 gnt=0001", tx_busy, grant);
        end
        rst_n = 1'b0;
        #1;
        vecs++;
        if (grant !== '0 || req_ack !== '0 || tx_wr_en !== 1'b0 || tx_din !== 8'h00 ||
            err !== 1'b0 || tx_clken !== 1'b0) begin
            miscompares++;
            $display("FAIL midframe_clear: got gnt=%b ack=%b wr=%b din=%h err=%b clken=%b, want all 0",
                     grant, req_ack, tx_wr_en, tx_din, err, tx_clken);
        end
        @(negedge clk_50m);
        rst_n = 1'b1;
        model_ptr = 1;
        drain("midframe");
        vecs++;
        if (bad_wr != 0) begin
            miscompares++;
            $display("FAIL midframe_collision: got %0d loads while busy, want 0", bad_wr);
        end
        vecs++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL midframe_frames: got %0d frames, want %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            logic [NR-1:0] oh;
            oh = NR'(1) << exp_q[k][9:8];
            vecs++;
            if (obs_q[k].ack !== oh || obs_q[k].gnt !== oh || obs_q[k].din !== exp_q[k][7:0]) begin
                miscompares++;
                $display("FAIL midframe_frame%0d: got ack=%b gnt=%b din=%h, want ack=gnt=%b din=%h",
                         k, obs_q[k].ack, obs_q[k].gnt, obs_q[k].din, oh, exp_q[k][7:0]);
            end
        end
    endtask

    initial begin
        req      = '0;
        req_data = '0;
        req_last = '0;
        test_reset();
        test_baud();
        test_single();
        test_alternate();
        test_multi_byte();
        test_random();
        test_err();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one byte-wide UART transmitter between NUM_REQ requesters using round-robin arbitration.
- Generates the transmitter's baud-rate clock enable.
- Sequences byte loads: drives wr_en/din, then tracks tx_busy until the frame completes.
- Supports multi-byte packets: the grant is held until the requester flags the last byte.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BAUD_DIV, 434, clk_50m cycles per bit period (50 MHz / 115200); minimum 2.
- WAIT_HI_MAX, 3, cycles allowed after a load for tx_busy to rise before an error is flagged.

Ports:
- clk_50m  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester request, level; held until last byte acked.
- req_data  input  8*NUM_REQ  byte for requester i in bits [8i+7:8i].
- req_last  input  NUM_REQ  current byte of requester i is the final byte of its packet.
- req_ack  output  NUM_REQ  one-cycle pulse: byte of requester i accepted; requester then presents the next byte or drops req.
- grant  output  NUM_REQ  one-hot current owner; all zero when idle.
- tx_din  output  8  byte to transmitter.
- tx_wr_en  output  1  load strobe to transmitter.
- tx_clken  output  1  baud tick to transmitter.
- tx_busy  input  1  transmitter busy status.
- err  output  1  sticky: tx_busy failed to rise within WAIT_HI_MAX cycles; cleared only by reset.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: grant, req_ack, tx_wr_en, tx_clken and err = 0; tx_din = 0.
  - Internal: baud counter = 0; FSM = S_IDLE; rr pointer = requester 0 has top priority.
- Baud generator: free-running counter 0..BAUD_DIV-1. tx_clken = 1 for exactly one cycle when count == BAUD_DIV-1, then wraps to 0. Independent of FSM state.
- FSM states: S_IDLE, S_LOAD, S_WAIT_HI, S_WAIT_LO.
- S_IDLE:
  - If any req bit = 1 and tx_busy = 0: pick the first set req at or after the rr pointer, wrapping modulo NUM_REQ.
  - Register the one-hot grant; go to S_LOAD.
  - If tx_busy = 1 (e.g. the transmitter was not reset), stay in S_IDLE.
- S_LOAD (exactly 1 cycle):
  - tx_wr_en = 1; tx_din = owner's req_data slice; req_ack[owner] = 1.
  - Latch req_last[owner] into last_q; clear the wait counter; go to S_WAIT_HI.
- S_WAIT_HI:
  - If tx_busy = 1: go to S_WAIT_LO.
  - Else increment the wait counter; when it reaches WAIT_HI_MAX: set err, release grant, advance rr, go to S_IDLE.
- S_WAIT_LO:
  - While tx_busy = 1: hold.
  - When tx_busy = 0 and (last_q = 1 or req[owner] = 0): release grant; rr pointer = owner+1 (mod NUM_REQ); go to S_IDLE.
  - Otherwise go to S_LOAD with the same owner: back-to-back byte, one idle cycle between busy-fall and the next wr_en.
- tx_wr_en and req_ack are decoded from the registered state and grant only, so they are glitch-free. tx_din is 0 outside S_LOAD.
- A requester dropping req while in S_LOAD, S_WAIT_HI or S_WAIT_LO does not abort the in-flight byte; the grant is released at frame end.
- Requests arriving mid-packet wait for packet completion; there is no preemption.
- If multiple requests are pending, each is served one packet per turn; no requester is starved.
- Reset mid-frame resets the arbiter only. The transmitter finishes its frame, and the S_IDLE tx_busy check prevents a collision.
- tx_busy rises the cycle after tx_wr_en in the target transmitter. WAIT_HI_MAX = 3 gives margin.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (2-bit localparams S_IDLE..S_WAIT_LO).
  - Default BAUD_DIV and clock-frequency constants.
- One sub-module: uart_baud_gen (counter + tx_clken tick, parameter BAUD_DIV, ports clk_50m, rst_n, tick).
- Round-robin select stays inline as a function.

Test Plan:
- BAUD_DIV=4, no requests -> tx_clken pulses every 4th cycle; grant stays 0; tx_wr_en stays 0.
- req=4'b0001, req_data[7:0]=8'hA5, req_last[0]=1 -> tx_wr_en=1 and req_ack=4'b0001 in the same cycle, tx_din=8'hA5; transmitter serialises 0,1,0,1,0,0,1,0,1 then stop; grant returns to 0 after busy falls.
- req=4'b1010 held, each byte last=1 -> grants alternate 4'b0010, 4'b1000, 4'b0010... one byte each, in order.
- Requester 2 sends a 3-byte packet (8'h11, 8'h22, 8'h33, last on the third) while req[0]=1 -> three consecutive frames from requester 2, then grant moves to requester 0 (pointer wrapped past 3).
- tx_busy tied 0 (stub) with req[1]=1 -> after 3 cycles in S_WAIT_HI, err=1 and grant released; err stays 1 until rst_n=0.
- rst_n pulsed low during S_WAIT_LO with the transmitter mid-frame -> outputs clear immediately; no new tx_wr_en until tx_busy=0.
